// File: rtl/col_readout_arbiter_if.sv
// Bus bundle between the column readout arbiter (slave side) and the pixel
// columns / global readout consumer (master side).
interface col_readout_arbiter_if #(
  parameter int NUM_COLS    = 16,
  parameter int DATA_WIDTH  = 46,
  parameter int COLID_WIDTH = 4,
  parameter int SUM_WIDTH   = 7
);
  logic                              readEn;
  logic [NUM_COLS-1:0]               colHitChain;
  logic [NUM_COLS*DATA_WIDTH-1:0]    colDataChain;
  logic [NUM_COLS-1:0]               colReadChain;
  logic [NUM_COLS*4-1:0]             trigHitsColumn;
  logic [SUM_WIDTH-1:0]              trigHitsSum;
  logic [COLID_WIDTH+DATA_WIDTH-1:0] dout;
  logic                              doutValid;
  logic                              doutReady;
  logic                              fifoFull;

  modport slave (
    input  readEn, colHitChain, colDataChain, trigHitsColumn, doutReady,
    output colReadChain, trigHitsSum, dout, doutValid, fifoFull
  );

  modport master (
    output readEn, colHitChain, colDataChain, trigHitsColumn, doutReady,
    input  colReadChain, trigHitsSum, dout, doutValid, fifoFull
  );
endinterface

// File: rtl/col_readout_arbiter.sv
// Round-robin column readout arbiter feeding a first-word-fall-through FIFO of
// {colID, data} words. Define TRIG_SUM_EN to build the trigger-hit popcount.
module col_readout_arbiter #(
  parameter int NUM_COLS    = 16,
  parameter int DATA_WIDTH  = 46,
  parameter int COLID_WIDTH = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int SUM_WIDTH   = 7
) (
  input  logic                 clkRO,
  input  logic                 rstn,
  col_readout_arbiter_if.slave bus
);
  localparam int WORD_W = COLID_WIDTH + DATA_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]             state;
  logic [COLID_WIDTH-1:0] rr_ptr;
  logic [COLID_WIDTH-1:0] gnt_q;
  logic [COLID_WIDTH-1:0] gnt_idx;
  logic [COLID_WIDTH:0]   gnt_off;
  logic [COLID_WIDTH:0]   gnt_sum;
  logic                   gnt_found;
  logic [NUM_COLS-1:0]    rot;
  logic [NUM_COLS-1:0]    read_q;
  logic [DATA_WIDTH-1:0]  rd_data;

  logic [WORD_W-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic [AW:0]            left;
  logic [WORD_W-1:0]      dout_q;
  logic [WORD_W-1:0]      dout_nxt;
  logic [WORD_W-1:0]      wdata;
  logic                   push;
  logic                   pop;
  logic                   room;
  logic                   grant;

  // Rotate hits so the round-robin pointer sits at bit 0; lowest set bit wins.
  assign rot = NUM_COLS'({bus.colHitChain, bus.colHitChain} >> rr_ptr);

  always_comb begin
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int i = NUM_COLS-1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_found = 1'b1;
        gnt_off   = (COLID_WIDTH+1)'(i);
      end
    end
  end

  assign gnt_sum = {1'b0, rr_ptr} + gnt_off;
  assign gnt_idx = (gnt_sum >= (COLID_WIDTH+1)'(NUM_COLS))
                 ? COLID_WIDTH'(gnt_sum - (COLID_WIDTH+1)'(NUM_COLS))
                 : gnt_sum[COLID_WIDTH-1:0];

  // A pop in the same cycle frees the slot the next grant will fill.
  assign pop   = (count != '0) && bus.doutReady;
  assign room  = (count != (AW+1)'(FIFO_DEPTH)) || pop;
  assign grant = (state == IDLE) && bus.readEn && gnt_found && room;
  assign push  = (state == READ);

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (gnt_q == COLID_WIDTH'(c)) rd_data = bus.colDataChain[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wdata = {gnt_q, rd_data};

  always_ff @(posedge clkRO) begin
    if (!rstn) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_q  <= '0;
      read_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state  <= READ;
            gnt_q  <= gnt_idx;
            read_q <= NUM_COLS'(1) << gnt_idx;
          end
        end
        READ: begin
          state  <= SETTLE;
          read_q <= '0;
          rr_ptr <= (gnt_q == COLID_WIDTH'(NUM_COLS-1)) ? '0 : gnt_q + 1'b1;
        end
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clkRO) begin
    if (rstn && push) mem[wr_ptr] <= wdata;
  end

  // dout is registered so it can hold the last word once the FIFO drains.
  always_comb begin
    left     = count - (AW+1)'(pop);
    dout_nxt = dout_q;
    if (left != '0)  dout_nxt = mem[rd_ptr + AW'(pop)];
    else if (push)   dout_nxt = wdata;
  end

  always_ff @(posedge clkRO) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      dout_q <= dout_nxt;
    end
  end

  assign bus.colReadChain = read_q;
  assign bus.dout         = dout_q;
  assign bus.doutValid    = (count != '0);
  assign bus.fifoFull     = (count == (AW+1)'(FIFO_DEPTH));

`ifdef TRIG_SUM_EN
  logic [NUM_COLS-1:0][2:0] col_cnt;
  logic [SUM_WIDTH-1:0]     trig_cnt;
  logic [SUM_WIDTH-1:0]     sum_q;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col_cnt
    assign col_cnt[c] = 3'(bus.trigHitsColumn[4*c])   + 3'(bus.trigHitsColumn[4*c+1])
                      + 3'(bus.trigHitsColumn[4*c+2]) + 3'(bus.trigHitsColumn[4*c+3]);
  end

  always_comb begin
    trig_cnt = '0;
    for (int c = 0; c < NUM_COLS; c++) trig_cnt = trig_cnt + SUM_WIDTH'(col_cnt[c]);
  end

  always_ff @(posedge clkRO) begin
    if (!rstn) sum_q <= '0;
    else       sum_q <= trig_cnt;
  end

  assign bus.trigHitsSum = sum_q;
`else
  logic unused_trig;
  assign unused_trig     = ^bus.trigHitsColumn;
  assign bus.trigHitsSum = '0;
`endif
endmodule

// File: tb/tb_col_readout_arbiter.sv
// Bench for col_readout_arbiter: trigger-sum vector table, directed corner
// sequences and randomized traffic checked by a queue-based reference model.
module tb_col_readout_arbiter;
  localparam int NC = 16, DW = 46, CW = 4, FD = 8, SW = 7, WW = CW + DW, QD = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  col_readout_arbiter_if #(.NUM_COLS(NC), .DATA_WIDTH(DW), .COLID_WIDTH(CW), .SUM_WIDTH(SW)) bus_i ();

  col_readout_arbiter #(.NUM_COLS(NC), .DATA_WIDTH(DW), .COLID_WIDTH(CW),
                        .FIFO_DEPTH(FD), .SUM_WIDTH(SW))
    dut (.clkRO(clk), .rstn(rstn), .bus(bus_i));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Column model: each column owns a small word queue; hit = queue not empty.
  logic [DW-1:0] cq [NC][QD];
  int            cq_head [NC];
  int            cq_cnt  [NC];
  logic [NC-1:0] hit_ovr = '0;

  task automatic add_word(input int c);
    cq[c][(cq_head[c] + cq_cnt[c]) % QD] = DW'({$urandom, $urandom});
    cq_cnt[c]++;
  endtask

  task automatic drive_cols();
    logic [NC-1:0] hits;
    hits = '0;
    for (int c = 0; c < NC; c++) begin
      hits[c] = (cq_cnt[c] != 0);
      bus_i.colDataChain[c*DW +: DW] = cq[c][cq_head[c]];
    end
    bus_i.colHitChain = hits | hit_ovr;
  endtask

  // Reference model: output FIFO as a queue, arbiter as round-robin pointer
  // plus the one-grant-per-three-cycles throughput rule.
  logic [WW-1:0] sb [$];
  logic [WW-1:0] dout_exp = '0;
  logic [SW-1:0] sum_exp  = '0;
  logic [SW-1:0] nxt_sum;
  int  rr = 0, since = 2, cur_col = 0, nxt_col = 0, cyc = 0;
  bit  cur_pulse = 0, nxt_pulse = 0, s_rstn, s_ready;
  int  plog_col [$];
  int  plog_cyc [$];

  function automatic int pending();
    int p;
    p = sb.size() + int'(cur_pulse);
    for (int c = 0; c < NC; c++) p += cq_cnt[c];
    return p;
  endfunction

  initial begin
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < QD; k++) cq[c][k] = '0;
    drive_cols();
    forever begin
      @(negedge clk); #1;
      drive_cols();
      check("colReadChain", bus_i.colReadChain, cur_pulse ? (64'd1 << cur_col) : 64'd0);
      check("doutValid", bus_i.doutValid, sb.size() != 0);
      check("fifoFull", bus_i.fifoFull, sb.size() == FD);
      check("dout", bus_i.dout, (sb.size() != 0) ? sb[0] : dout_exp);
      check("trigHitsSum", bus_i.trigHitsSum, sum_exp);
      for (int c = 0; c < NC; c++)
        if (bus_i.colReadChain[c]) begin plog_col.push_back(c); plog_cyc.push_back(cyc); end

      s_rstn    = rstn;
      s_ready   = bus_i.doutReady;
      nxt_pulse = 0;
      if (rstn && since >= 2 && bus_i.readEn && bus_i.colHitChain != '0 &&
          (sb.size() < FD || (sb.size() != 0 && bus_i.doutReady))) begin
        nxt_pulse = 1;
        for (int k = 0; k < NC; k++)
          if (bus_i.colHitChain[(rr + k) % NC]) begin nxt_col = (rr + k) % NC; break; end
      end
`ifdef TRIG_SUM_EN
      nxt_sum = rstn ? SW'($countones(bus_i.trigHitsColumn)) : '0;
`else
      nxt_sum = '0;
`endif

      @(posedge clk); #1;
      cyc++;
      if (!s_rstn) begin
        sb.delete();
        rr = 0; since = 2; cur_pulse = 0; dout_exp = '0;
      end else begin
        if (sb.size() != 0 && s_ready) void'(sb.pop_front());
        if (cur_pulse) begin
          sb.push_back({CW'(cur_col), cq[cur_col][cq_head[cur_col]]});
          cq_head[cur_col] = (cq_head[cur_col] + 1) % QD;
          cq_cnt[cur_col]--;
          rr = (cur_col + 1) % NC;
        end
        cur_pulse = nxt_pulse;
        cur_col   = nxt_col;
        since     = nxt_pulse ? 0 : ((since < 2) ? since + 1 : 2);
      end
      if (sb.size() != 0) dout_exp = sb[0];
      sum_exp = nxt_sum;
    end
  end

  task automatic wait_pulse(input int col, input int budget, input string name);
    int n;
    n = 0;
    while (bus_i.colReadChain[col] !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check(name, bus_i.colReadChain[col], 1'b1);
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    bus_i.readEn = 1'b1; bus_i.doutReady = 1'b1;
    while (pending() != 0 && n < budget) begin @(negedge clk); n++; end
    check(name, pending(), 0);
  endtask

  typedef struct {
    logic [NC*4-1:0] trig;
    logic [SW-1:0]   sum;
  } tvec_t;

  tvec_t tv [9];

  initial begin
    tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64};
    tv[1] = '{64'h0000_0000_0000_0000, 7'd0};
    tv[2] = '{64'h0000_0000_0000_0001, 7'd1};
    tv[3] = '{64'h8000_0000_0000_0001, 7'd2};
    tv[4] = '{64'hF0F0_F0F0_F0F0_F0F0, 7'd32};
    tv[5] = '{64'h0123_4567_89AB_CDEF, 7'd32};
    tv[6] = '{64'hFFFF_0000_0000_0007, 7'd19};
    tv[7] = '{64'h0000_0001_0000_0000, 7'd1};
    tv[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 7'd63};

    // Reset held with every column claiming a hit.
    bus_i.readEn = 1'b1; bus_i.doutReady = 1'b1;
    bus_i.trigHitsColumn = '1;
    hit_ovr = '1;
    repeat (3) begin
      @(negedge clk);
      check("rst_colReadChain", bus_i.colReadChain, 0);
      check("rst_doutValid", bus_i.doutValid, 0);
      check("rst_trigHitsSum", bus_i.trigHitsSum, 0);
    end
    hit_ovr = '0;
    rstn = 1'b1;

    // Trigger popcount vectors, one-cycle latency.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus_i.trigHitsColumn = tv[i].trig;
      @(negedge clk);
`ifdef TRIG_SUM_EN
      check("trig_vec", bus_i.trigHitsSum, tv[i].sum);
`else
      check("trig_vec_off", bus_i.trigHitsSum, 0);
`endif
    end

    // Round robin over columns 3, 7, 15, then wrap order 3 before 14.
    @(negedge clk);
    plog_col.delete(); plog_cyc.delete();
    add_word(3); add_word(7); add_word(15);
    drain(100, "rr_drain");
    check("rr_reads", plog_col.size(), 3);
    if (plog_col.size() >= 3) begin
      check("rr_col0", plog_col[0], 3);
      check("rr_col1", plog_col[1], 7);
      check("rr_col2", plog_col[2], 15);
      check("rr_gap1", plog_cyc[1] - plog_cyc[0], 3);
      check("rr_gap2", plog_cyc[2] - plog_cyc[1], 3);
    end
    plog_col.delete(); plog_cyc.delete();
    add_word(14); add_word(3);
    drain(100, "wrap_drain");
    check("wrap_reads", plog_col.size(), 2);
    if (plog_col.size() >= 2) begin
      check("wrap_first", plog_col[0], 3);
      check("wrap_second", plog_col[1], 14);
    end

    // Backpressure: twelve columns pending, consumer stalled.
    plog_col.delete(); plog_cyc.delete();
    bus_i.doutReady = 1'b0;
    for (int c = 0; c < 12; c++) add_word(c);
    repeat (50) @(negedge clk);
    check("bp_reads", plog_col.size(), 8);
    check("bp_full", bus_i.fifoFull, 1);
    bus_i.doutReady = 1'b1;
    @(negedge clk);
    bus_i.doutReady = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_one_more", plog_col.size(), 9);
    check("bp_full_again", bus_i.fifoFull, 1);
    drain(300, "bp_drain");

    // readEn gating, then readEn dropped during the READ cycle.
    plog_col.delete(); plog_cyc.delete();
    bus_i.readEn = 1'b0; bus_i.doutReady = 1'b0;
    add_word(4);
    repeat (10) @(negedge clk);
    check("gate_no_read", plog_col.size(), 0);
    bus_i.readEn = 1'b1;
    wait_pulse(4, 10, "gate_pulse");
    bus_i.readEn = 1'b0;
    repeat (3) @(negedge clk);
    check("gate_written", bus_i.doutValid, 1);
    check("gate_colid", bus_i.dout[WW-1 -: CW], 4);
    drain(50, "gate_drain");

    // Reset asserted in the READ cycle of column 5.
    add_word(5);
    wait_pulse(5, 10, "mr_pulse");
    rstn = 1'b0;
    @(negedge clk);
    check("mr_read_cleared", bus_i.colReadChain, 0);
    check("mr_no_write", bus_i.doutValid, 0);
    rstn = 1'b1;
    wait_pulse(5, 10, "mr_served_after");
    drain(50, "mr_drain");

    // Randomized traffic with stall windows and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      int c;
      @(negedge clk);
      bus_i.readEn    = ($urandom_range(0, 7) != 0);
      bus_i.doutReady = ((i % 300) < 80) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rstn            = !((i % 997) == 500);
      bus_i.trigHitsColumn = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        c = int'($urandom_range(0, NC-1));
        if (cq_cnt[c] < 3) add_word(c);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    drain(600, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
